// File: rtl/handshake_monitor_if.sv
// handshake_monitor_if: monitored valid/ready/data bundle plus the monitor's counters and sticky error flags
interface handshake_monitor_if #(
   parameter int N_CH   = 3,
   parameter int DATA_W = 4,
   parameter int CNT_W  = 16
);
   logic                     clear;
   logic [N_CH-1:0]          valid;
   logic [N_CH-1:0]          ready;
   logic [N_CH*DATA_W-1:0]   data;
   logic [N_CH*CNT_W-1:0]    xfer_count;
   logic [N_CH-1:0]          err_drop;
   logic [N_CH-1:0]          err_change;
   logic [N_CH-1:0]          err_timeout;
   logic                     err_any;
   modport master (
      output clear, valid, ready, data,
      input  xfer_count, err_drop, err_change, err_timeout, err_any
   );
   modport slave (
      input  clear, valid, ready, data,
      output xfer_count, err_drop, err_change, err_timeout, err_any
   );
endinterface

// File: rtl/handshake_monitor.sv
// handshake_monitor: per-channel valid/ready protocol checker with transfer counters and sticky error flags.
// Define HANDSHAKE_MONITOR_ASSERT_EN to compile per-channel concurrent assertions for drop/change/timeout.
module handshake_monitor #(
   parameter int N_CH      = 3,
   parameter int DATA_W    = 4,
   parameter int CNT_W     = 16,
   parameter int STALL_MAX = 16
) (
   input logic                CLK,
   input logic                RESET,
   handshake_monitor_if.slave mon
);
   typedef enum logic {IDLE, STALL} state_t;
   localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(STALL_MAX);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   state_t            state_q [N_CH];
   state_t            state_d [N_CH];
   logic [DATA_W-1:0] cap_q   [N_CH];
   logic [DATA_W-1:0] cap_d   [N_CH];
   logic [CNT_W-1:0]  stall_q [N_CH];
   logic [CNT_W-1:0]  stall_d [N_CH];
   logic [CNT_W-1:0]  cnt_q   [N_CH];
   logic [CNT_W-1:0]  cnt_d   [N_CH];
   logic [N_CH-1:0]   drop_q, drop_d, change_q, change_d, timeout_q, timeout_d;
   logic              any_q, any_d;
   logic [N_CH-1:0]   xfer, stall, stalled, drop_ev, change_ev, timeout_ev;
   logic [CNT_W-1:0]  stall_base [N_CH];
   logic [CNT_W-1:0]  cnt_base   [N_CH];
   // clear acts as a zero base, so an event in the same cycle still sets/increments
   always_comb begin
      for (int i = 0; i < N_CH; i++) begin
         xfer[i]       = mon.valid[i] & mon.ready[i];
         stall[i]      = mon.valid[i] & ~mon.ready[i];
         stalled[i]    = state_q[i] == STALL;
         drop_ev[i]    = stalled[i] & ~mon.valid[i];
         change_ev[i]  = stalled[i] & mon.valid[i] & (mon.data[i*DATA_W +: DATA_W] != cap_q[i]);
         stall_base[i] = mon.clear ? '0 : stall_q[i];
         cnt_base[i]   = mon.clear ? '0 : cnt_q[i];
         stall_d[i]    = !stall[i] ? '0 : (stall_base[i] >= STALL_LIM ? STALL_LIM : stall_base[i] + CNT_W'(1));
         timeout_ev[i] = stall_d[i] == STALL_LIM;
         cnt_d[i]      = (xfer[i] && cnt_base[i] != CNT_MAX) ? cnt_base[i] + CNT_W'(1) : cnt_base[i];
         state_d[i]    = stall[i] ? STALL : IDLE;
         cap_d[i]      = (stall[i] && (!stalled[i] || mon.clear)) ? mon.data[i*DATA_W +: DATA_W] : cap_q[i];
      end
      drop_d    = (mon.clear ? '0 : drop_q) | drop_ev;
      change_d  = (mon.clear ? '0 : change_q) | change_ev;
      timeout_d = (mon.clear ? '0 : timeout_q) | timeout_ev;
      any_d     = |{drop_d, change_d, timeout_d};
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= IDLE;
            cap_q[i]   <= '0;
            stall_q[i] <= '0;
            cnt_q[i]   <= '0;
         end
         drop_q    <= '0;
         change_q  <= '0;
         timeout_q <= '0;
         any_q     <= 1'b0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            state_q[i] <= state_d[i];
            cap_q[i]   <= cap_d[i];
            stall_q[i] <= stall_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         drop_q    <= drop_d;
         change_q  <= change_d;
         timeout_q <= timeout_d;
         any_q     <= any_d;
      end
   end
   always_comb begin
      for (int i = 0; i < N_CH; i++) mon.xfer_count[i*CNT_W +: CNT_W] = cnt_q[i];
   end
   assign mon.err_drop    = drop_q;
   assign mon.err_change  = change_q;
   assign mon.err_timeout = timeout_q;
   assign mon.err_any     = any_q;
`ifdef HANDSHAKE_MONITOR_ASSERT_EN
   for (genvar g = 0; g < N_CH; g++) begin : g_chk
      a_drop: assert property (@(posedge CLK) disable iff (RESET) !drop_ev[g])
         else $error("handshake_monitor: valid dropped while stalled on channel %0d", g);
      a_change: assert property (@(posedge CLK) disable iff (RESET) !change_ev[g])
         else $error("handshake_monitor: payload changed while stalled on channel %0d", g);
      a_timeout: assert property (@(posedge CLK) disable iff (RESET) !timeout_ev[g])
         else $error("handshake_monitor: stall timeout on channel %0d", g);
   end
`else
`endif
endmodule

// File: tb/tb_handshake_monitor.sv
// tb_handshake_monitor: directed scoreboard bench for handshake_monitor (wide counters and a CNT_W=4 instance).
module tb_handshake_monitor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   logic [63:0] exp_q [$];
   always #5 clk = ~clk;
   handshake_monitor_if #(.N_CH(3), .DATA_W(4), .CNT_W(16)) a_if ();
   handshake_monitor_if #(.N_CH(3), .DATA_W(4), .CNT_W(4))  b_if ();
   handshake_monitor #(.N_CH(3), .DATA_W(4), .CNT_W(16), .STALL_MAX(16)) dut_a (.CLK(clk), .RESET(rst), .mon(a_if.slave));
   handshake_monitor #(.N_CH(3), .DATA_W(4), .CNT_W(4),  .STALL_MAX(8))  dut_b (.CLK(clk), .RESET(rst), .mon(b_if.slave));
   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic push(input logic [63:0] v);
      exp_q.push_back(v);
   endtask
   task automatic chk(input string tag, input logic [63:0] obs);
      logic [63:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
         end
      end
   endtask
   function automatic logic [63:0] cnt_a(input int i);
      return 64'(a_if.xfer_count[i*16 +: 16]);
   endfunction
   function automatic logic [63:0] cnt_b(input int i);
      return 64'(b_if.xfer_count[i*4 +: 4]);
   endfunction
   task automatic idle_a();
      a_if.valid = '0; a_if.ready = '0; a_if.clear = 1'b0;
   endtask
   task automatic idle_b();
      b_if.valid = '0; b_if.ready = '0; b_if.clear = 1'b0;
   endtask
   initial begin
      idle_a(); idle_b();
      a_if.data = '0; b_if.data = '0;
      step(2);
      rst = 1'b0;
      push(0); push(0); push(0); push(0); push(0);
      step();
      chk("rst_count", 64'(a_if.xfer_count));
      chk("rst_drop", 64'(a_if.err_drop));
      chk("rst_change", 64'(a_if.err_change));
      chk("rst_timeout", 64'(a_if.err_timeout));
      chk("rst_any", 64'(a_if.err_any));
      // five back-to-back transfers on ch0
      a_if.valid = 3'b001; a_if.ready = 3'b001;
      push(5); push(0); push(0); push(0);
      step(5);
      idle_a();
      chk("xfer5_ch0", cnt_a(0));
      chk("xfer5_ch1", cnt_a(1));
      chk("xfer5_ch2", cnt_a(2));
      chk("xfer5_any", 64'(a_if.err_any));
      // drop on ch1
      a_if.valid = 3'b010; a_if.data[4 +: 4] = 4'hA;
      step(2);
      a_if.valid = 3'b000;
      push(3'b010); push(1); push(0); push(0);
      step();
      chk("drop_flag", 64'(a_if.err_drop));
      chk("drop_any", 64'(a_if.err_any));
      chk("drop_change", 64'(a_if.err_change));
      chk("drop_timeout", 64'(a_if.err_timeout));
      a_if.clear = 1'b1;
      push(0); push(0); push(0);
      step();
      a_if.clear = 1'b0;
      chk("clear_drop", 64'(a_if.err_drop));
      chk("clear_any", 64'(a_if.err_any));
      chk("clear_cnt0", cnt_a(0));
      // payload change on ch2, completing as a transfer
      a_if.valid = 3'b100; a_if.data[8 +: 4] = 4'h3;
      step();
      a_if.ready = 3'b100; a_if.data[8 +: 4] = 4'h5;
      push(3'b100); push(1); push(0);
      step();
      idle_a();
      chk("change_flag", 64'(a_if.err_change));
      chk("change_cnt2", cnt_a(2));
      chk("change_drop", 64'(a_if.err_drop));
      a_if.clear = 1'b1;
      step();
      a_if.clear = 1'b0;
      // ch0 timeout after 16 stall cycles
      a_if.valid = 3'b001; a_if.data[0 +: 4] = 4'h7;
      push(0);
      step(15);
      chk("timeout_15", 64'(a_if.err_timeout));
      push(3'b001); push(1);
      step();
      chk("timeout_16", 64'(a_if.err_timeout));
      chk("timeout_any", 64'(a_if.err_any));
      push(3'b001);
      step(3);
      chk("timeout_sticky", 64'(a_if.err_timeout));
      a_if.ready = 3'b001;
      push(3'b001); push(0);
      step();
      chk("timeout_after_xfer", 64'(a_if.err_timeout));
      chk("timeout_no_change", 64'(a_if.err_change));
      idle_a();
      a_if.clear = 1'b1;
      step();
      a_if.clear = 1'b0;
      a_if.valid = 3'b001;
      step(15);
      a_if.ready = 3'b001;
      push(0); push(1);
      step();
      idle_a();
      chk("stall15_timeout", 64'(a_if.err_timeout));
      chk("stall15_cnt0", cnt_a(0));
      a_if.clear = 1'b1;
      step();
      a_if.clear = 1'b0;
      // simultaneous events on all channels
      a_if.valid = 3'b011; a_if.ready = 3'b000;
      a_if.data[0 +: 4] = 4'h1; a_if.data[4 +: 4] = 4'h2;
      step();
      a_if.valid = 3'b110; a_if.ready = 3'b100; a_if.data[4 +: 4] = 4'h3;
      push(3'b001); push(3'b010); push(1); push(1);
      step();
      chk("multi_drop", 64'(a_if.err_drop));
      chk("multi_change", 64'(a_if.err_change));
      chk("multi_cnt2", cnt_a(2));
      chk("multi_any", 64'(a_if.err_any));
      // clear coincident with a transfer on ch0 and a drop on ch1
      a_if.valid = 3'b001; a_if.ready = 3'b001; a_if.clear = 1'b1;
      push(1); push(0); push(3'b010); push(0); push(1);
      step();
      idle_a();
      chk("clrwin_cnt0", cnt_a(0));
      chk("clrwin_cnt2", cnt_a(2));
      chk("clrwin_drop", 64'(a_if.err_drop));
      chk("clrwin_change", 64'(a_if.err_change));
      chk("clrwin_any", 64'(a_if.err_any));
      // 4-bit counter saturation
      b_if.valid = 3'b001; b_if.ready = 3'b001;
      push(15); push(0);
      step(20);
      chk("sat_cnt0", cnt_b(0));
      chk("sat_cnt1", cnt_b(1));
      b_if.clear = 1'b1;
      push(1);
      step();
      b_if.clear = 1'b0;
      chk("sat_clear_xfer", cnt_b(0));
      // reset mid-stall, overriding clear and a transfer
      b_if.valid = 3'b010; b_if.ready = 3'b000; b_if.data[4 +: 4] = 4'h9;
      step();
      rst = 1'b1;
      b_if.valid = 3'b011; b_if.ready = 3'b001; b_if.clear = 1'b1;
      step();
      rst = 1'b0;
      idle_b();
      push(0); push(0); push(0); push(0);
      step();
      chk("rst_stall_drop", 64'(b_if.err_drop));
      chk("rst_stall_any", 64'(b_if.err_any));
      chk("rst_over_cnt0", cnt_b(0));
      chk("rst_a_cnt0", cnt_a(0));
      if (exp_q.size() != 0) begin
         errors++;
         $error("FAIL leftover: observed %0d queued expectations, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
